// File: rtl/mem_resp_pkg.sv
// Shared types and helpers for the memory responder: FSM states, channel ids,
// byte-lane mask generation and request error classification.
package mem_resp_pkg;

    localparam int XLEN = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic {
        CH_INST = 1'b0,
        CH_DATA = 1'b1
    } chan_e;

    // Byte-lane enables for a store of len bytes starting at lane off.
    function automatic logic [7:0] byte_mask(input logic [2:0] off, input logic [3:0] len);
        logic [15:0] m;
        m = (16'h0001 << len) - 16'h0001;
        m = m << off;
        return m[7:0];
    endfunction

    // True when a request must be answered with err=1 and no array effect.
    function automatic logic req_error(input chan_e ch, input logic wr,
                                       input logic [XLEN-1:0] addr, input logic [7:0] len,
                                       input logic [XLEN-1:0] base, input logic [XLEN-1:0] span);
        logic err;
        err = 1'b0;
        // Range test written as an offset compare so base+span never has to fit.
        if ((addr < base) || ((addr - base) >= span)) begin
            err = 1'b1;
        end
        if (ch == CH_INST) begin
            if (addr[1:0] != 2'b00) begin
                err = 1'b1;
            end
        end else if (wr) begin
            if (!((len == 8'd1) || (len == 8'd2) || (len == 8'd4) || (len == 8'd8))) begin
                err = 1'b1;
            end
            if (({6'b0, addr[2:0]} + {1'b0, len}) > 9'd8) begin
                err = 1'b1;
            end
        end
        return err;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Instruction and data request/response channels between the core and the
// memory responder. The core is the master, the responder the slave.
interface mem_responder_if;
    import mem_resp_pkg::*;

    logic            iInstReqValid;
    logic            oInstReqReady;
    logic [XLEN-1:0] iInstAddr;
    logic            oInstRespValid;
    logic            iInstRespReady;
    logic [XLEN-1:0] oInstRdData;
    logic            oInstErr;

    logic            iDataReqValid;
    logic            oDataReqReady;
    logic            iDataWrEn;
    logic [XLEN-1:0] iDataAddr;
    logic [XLEN-1:0] iDataWrData;
    logic [7:0]      iDataWrLen;
    logic            oDataRespValid;
    logic            iDataRespReady;
    logic [XLEN-1:0] oDataRdData;
    logic            oDataErr;

    modport slave (
        input  iInstReqValid, iInstAddr, iInstRespReady,
        input  iDataReqValid, iDataWrEn, iDataAddr, iDataWrData, iDataWrLen, iDataRespReady,
        output oInstReqReady, oInstRespValid, oInstRdData, oInstErr,
        output oDataReqReady, oDataRespValid, oDataRdData, oDataErr
    );

    modport master (
        output iInstReqValid, iInstAddr, iInstRespReady,
        output iDataReqValid, iDataWrEn, iDataAddr, iDataWrData, iDataWrLen, iDataRespReady,
        input  oInstReqReady, oInstRespValid, oInstRdData, oInstErr,
        input  oDataReqReady, oDataRespValid, oDataRdData, oDataErr
    );

endinterface

// File: rtl/mem_resp_array.sv
// Single-port 64-bit word array: per-byte write enables, synchronous write,
// combinational read. Contents are never reset.
module mem_resp_array
    import mem_resp_pkg::*;
#(
    parameter int    DEPTH_WORDS = 4096,
    parameter string INIT_FILE   = "",
    parameter int    AW          = $clog2(DEPTH_WORDS)
) (
    input  logic            clk,
    input  logic [AW-1:0]   addr,
    input  logic            we,
    input  logic [7:0]      be,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] rdata
);

    logic [XLEN-1:0] mem [0:DEPTH_WORDS-1];

    // Byte-granular write of the enabled lanes.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 8; b++) begin
                if (be[b]) begin
                    mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Memory responder: arbitrates the instruction and data channels onto one
// array, one outstanding transaction, fixed LATENCY from accept to response.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR   = 64'h8000_0000,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          LATENCY     = 1,
    parameter string       INIT_FILE   = ""
) (
    input  logic iClock,
    input  logic iResetN,
    mem_responder_if.slave bus
);

    localparam int              AW    = $clog2(DEPTH_WORDS);
    localparam int              CNT_W = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);
    localparam logic [XLEN-1:0] SPAN  = XLEN'(DEPTH_WORDS) * 64'd8;

    generate
        if (LATENCY < 1) begin : g_bad_latency
            $error("mem_responder: LATENCY must be at least 1");
        end
        if ((1 << AW) != DEPTH_WORDS) begin : g_bad_depth
            $error("mem_responder: DEPTH_WORDS must be a power of two");
        end
    endgenerate

    state_e             state_q, state_d;
    chan_e              chan_q, chan_d;
    logic               wr_q, wr_d;
    logic [XLEN-1:0]    addr_q, addr_d;
    logic [XLEN-1:0]    wdata_q, wdata_d;
    logic [7:0]         len_q, len_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0]    rd_q, rd_d;
    logic               err_q, err_d;

    chan_e              op_chan;
    logic               op_wr;
    logic [XLEN-1:0]    op_addr;
    logic [XLEN-1:0]    op_wdata;
    logic [7:0]         op_len;
    logic               op_err;

    logic               idle;
    logic               inst_ready;
    logic               data_ready;
    logic               accept;
    logic               resp_ready;
    logic               do_access;

    logic [AW-1:0]      arr_idx;
    logic               arr_we;
    logic [7:0]         arr_be;
    logic [XLEN-1:0]    arr_wdata;
    logic [XLEN-1:0]    arr_rdata;

    // Readies are forced low while reset is held so the outputs read 0.
    assign idle       = (state_q == ST_IDLE) && iResetN;
    assign data_ready = idle;
    assign inst_ready = idle && !bus.iDataReqValid;
    assign accept     = (data_ready && bus.iDataReqValid) || (inst_ready && bus.iInstReqValid);
    assign resp_ready = (chan_q == CH_DATA) ? bus.iDataRespReady : bus.iInstRespReady;

    // Operation under consideration: live request in IDLE, latched one otherwise.
    // With LATENCY 1 the access happens on the accept edge from the live inputs.
    always_comb begin
        op_chan  = chan_q;
        op_wr    = wr_q;
        op_addr  = addr_q;
        op_wdata = wdata_q;
        op_len   = len_q;
        if (state_q == ST_IDLE) begin
            if (bus.iDataReqValid) begin
                op_chan  = CH_DATA;
                op_wr    = bus.iDataWrEn;
                op_addr  = bus.iDataAddr;
                op_wdata = bus.iDataWrData;
                op_len   = bus.iDataWrLen;
            end else begin
                op_chan  = CH_INST;
                op_wr    = 1'b0;
                op_addr  = bus.iInstAddr;
                op_wdata = '0;
                op_len   = '0;
            end
        end
        op_err    = req_error(op_chan, op_wr, op_addr, op_len, BASE_ADDR, SPAN);
        arr_idx   = AW'((op_addr - BASE_ADDR) >> 3);
        arr_be    = byte_mask(op_addr[2:0], op_len[3:0]);
        arr_wdata = op_wdata << {op_addr[2:0], 3'b000};
    end

    // Next-state: accept, latency countdown, access on entry to RESP, hold until consumed.
    always_comb begin
        state_d   = state_q;
        chan_d    = chan_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        rd_d      = rd_q;
        err_d     = err_q;
        do_access = 1'b0;
        arr_we    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    chan_d  = op_chan;
                    wr_d    = op_wr;
                    addr_d  = op_addr;
                    wdata_d = op_wdata;
                    len_d   = op_len;
                    if (LATENCY == 1) begin
                        do_access = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            ST_WAIT: begin
                // The count reaching its last step means this edge raises valid.
                if (cnt_q <= CNT_W'(1)) begin
                    do_access = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                    rd_d    = '0;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (do_access) begin
            state_d = ST_RESP;
            cnt_d   = '0;
            err_d   = op_err;
            rd_d    = (op_err || op_wr) ? '0 : arr_rdata;
            arr_we  = op_wr && !op_err;
        end
    end

    // State and transaction registers; reset abandons any in-flight request.
    always_ff @(posedge iClock or negedge iResetN) begin
        if (!iResetN) begin
            state_q <= ST_IDLE;
            chan_q  <= CH_INST;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            rd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            chan_q  <= chan_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
        end
    end

    mem_resp_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .INIT_FILE   (INIT_FILE),
        .AW          (AW)
    ) u_array (
        .clk   (iClock),
        .addr  (arr_idx),
        .we    (arr_we),
        .be    (arr_be),
        .wdata (arr_wdata),
        .rdata (arr_rdata)
    );

    assign bus.oDataReqReady  = data_ready;
    assign bus.oInstReqReady  = inst_ready;
    assign bus.oInstRespValid = (state_q == ST_RESP) && (chan_q == CH_INST);
    assign bus.oDataRespValid = (state_q == ST_RESP) && (chan_q == CH_DATA);
    assign bus.oInstRdData    = (chan_q == CH_INST) ? rd_q : '0;
    assign bus.oDataRdData    = (chan_q == CH_DATA) ? rd_q : '0;
    assign bus.oInstErr       = bus.oInstRespValid && err_q;
    assign bus.oDataErr       = bus.oDataRespValid && err_q;

endmodule
